// File: rtl/sync_pkg.sv
// Helpers shared by the bus synchroniser: Gray decode, bit counting and the
// width of the stability counter.
package sync_pkg;

  // Widest bus the helpers handle; callers zero-extend into this width.
  localparam int SYNC_MAX_W = 64;

  // Zero-extension is harmless: leading zero Gray bits decode to zero bits.
  function automatic logic [SYNC_MAX_W-1:0] gray2bin(input logic [SYNC_MAX_W-1:0] g);
    logic [SYNC_MAX_W-1:0] b;
    b[SYNC_MAX_W-1] = g[SYNC_MAX_W-1];
    for (int i = SYNC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int popcount(input logic [SYNC_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SYNC_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit metastability chain; the last stage is the synchronised bit.
module sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[NUM_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_filtered.sv
// Multi-bit synchroniser with a stability filter: the output bus only takes a
// value the synchronised bus has held unchanged for STABLE_CYCLES cycles.
module bus_sync_filtered
  import sync_pkg::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int BUS_WIDTH     = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int GRAY_MODE     = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  input  logic                 EN,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic                 SYNC_VALID,
  output logic                 CHANGE,
  output logic                 GRAY_ERR
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("bus_sync_filtered: NUM_STAGES must be >= 2");
  end
  if (BUS_WIDTH < 1 || BUS_WIDTH > SYNC_MAX_W) begin : g_bad_width
    $error("bus_sync_filtered: BUS_WIDTH out of range");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("bus_sync_filtered: STABLE_CYCLES must be >= 1");
  end

  logic [BUS_WIDTH-1:0] sync_q;
  logic [BUS_WIDTH-1:0] prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 change_q, change_d;
  logic                 gerr_q, gerr_d;
  logic                 accept;
  logic [BUS_WIDTH-1:0] val;

  for (genvar b = 0; b < BUS_WIDTH; b++) begin : g_chain
    sync_chain #(.NUM_STAGES(NUM_STAGES)) u_chain (
      .clk_i  (CLK),
      .rst_n_i(RST),
      .d_i    (ASYNC[b]),
      .q_o    (sync_q[b])
    );
  end

  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    gerr_d   = gerr_q;
    accept   = (cnt_q == CNT_MAX) && EN;
    val      = (GRAY_MODE != 0) ? BUS_WIDTH'(gray2bin(SYNC_MAX_W'(prev_q))) : prev_q;

    if (sync_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    // prev_q is the value that has been stable for the counted cycles.
    if (accept) begin
      out_d    = val;
      valid_d  = 1'b1;
      change_d = (val != out_q);
    end

    if ((GRAY_MODE != 0) && (popcount(SYNC_MAX_W'(sync_q ^ prev_q)) > 1)) begin
      gerr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      gerr_q   <= 1'b0;
    end else begin
      prev_q   <= sync_q;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      gerr_q   <= gerr_d;
    end
  end

  assign SYNC       = out_q;
  assign SYNC_VALID = valid_q;
  assign CHANGE     = change_q;
  assign GRAY_ERR   = gerr_q;

endmodule

// File: tb/tb_bus_sync_filtered.sv
// Scoreboard bench: a binary instance and a Gray-mode instance; expected SYNC
// values are queued at stimulus time and popped whenever CHANGE pulses.
module tb_bus_sync_filtered;

  logic       CLK = 1'b0;
  logic       RST, RST_G;
  logic [3:0] ASYNC, ASYNC_G;
  logic       EN, EN_G;
  logic [3:0] SYNC, SYNC_G;
  logic       SYNC_VALID, SYNC_VALID_G;
  logic       CHANGE, CHANGE_G;
  logic       GRAY_ERR, GRAY_ERR_G;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_g[$];
  logic [3:0] last_sync, last_sync_g;

  // Hand-written 4-bit Gray sequence for binary 0..15.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 CLK = ~CLK;

  bus_sync_filtered #(.NUM_STAGES(2), .BUS_WIDTH(4), .STABLE_CYCLES(2), .GRAY_MODE(0)) dut (
    .CLK(CLK), .RST(RST), .ASYNC(ASYNC), .EN(EN),
    .SYNC(SYNC), .SYNC_VALID(SYNC_VALID), .CHANGE(CHANGE), .GRAY_ERR(GRAY_ERR)
  );

  bus_sync_filtered #(.NUM_STAGES(2), .BUS_WIDTH(4), .STABLE_CYCLES(2), .GRAY_MODE(1)) dut_g (
    .CLK(CLK), .RST(RST_G), .ASYNC(ASYNC_G), .EN(EN_G),
    .SYNC(SYNC_G), .SYNC_VALID(SYNC_VALID_G), .CHANGE(CHANGE_G), .GRAY_ERR(GRAY_ERR_G)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor for the binary instance.
  always @(negedge CLK) begin
    if (CHANGE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", {28'h0, SYNC}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_sync", {28'h0, SYNC}, {28'h0, exp_q.pop_front()});
      end
    end else if (RST && SYNC !== last_sync) begin
      chk("silent_sync_move", {28'h0, SYNC}, {28'h0, last_sync});
    end
    last_sync = SYNC;
  end

  // Monitor for the Gray instance.
  always @(negedge CLK) begin
    if (CHANGE_G) begin
      if (exp_g.size() == 0) begin
        chk("unexpected_change_g", {28'h0, SYNC_G}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_sync_g", {28'h0, SYNC_G}, {28'h0, exp_g.pop_front()});
      end
    end else if (RST_G && SYNC_G !== last_sync_g) begin
      chk("silent_sync_move_g", {28'h0, SYNC_G}, {28'h0, last_sync_g});
    end
    last_sync_g = SYNC_G;
  end

  initial begin
    RST = 1'b0; ASYNC = 4'h0; EN = 1'b1;
    RST_G = 1'b0; ASYNC_G = 4'h0; EN_G = 1'b1;
    last_sync = 4'h0; last_sync_g = 4'h0;

    // Startup
    tick(2);
    chk("rst_sync", {28'h0, SYNC}, 32'h0);
    chk("rst_valid", {31'h0, SYNC_VALID}, 32'h0);
    chk("rst_change", {31'h0, CHANGE}, 32'h0);
    chk("rst_gerr_g", {31'h0, GRAY_ERR_G}, 32'h0);
    RST = 1'b1;
    tick(2);
    chk("start_valid_e2", {31'h0, SYNC_VALID}, 32'h0);
    tick(1);
    chk("start_valid_e3", {31'h0, SYNC_VALID}, 32'h1);
    chk("start_sync", {28'h0, SYNC}, 32'h0);

    // Step 0 -> 5
    ASYNC = 4'h5; exp_q.push_back(4'h5);
    tick(5);
    chk("step_e5", {28'h0, SYNC}, 32'h0);
    tick(1);
    chk("step_e6", {28'h0, SYNC}, 32'h5);
    chk("step_change", {31'h0, CHANGE}, 32'h1);
    tick(1);
    chk("step_change_1cyc", {31'h0, CHANGE}, 32'h0);
    chk("step_valid", {31'h0, SYNC_VALID}, 32'h1);

    // Glitching bus: 6 settles, 9/6 alternation rejected, then 9 settles
    ASYNC = 4'h6; exp_q.push_back(4'h6);
    tick(8);
    chk("glitch_pre", {28'h0, SYNC}, 32'h6);
    for (int i = 0; i < 10; i++) begin
      ASYNC = (i % 2 == 0) ? 4'h9 : 4'h6;
      tick(1);
    end
    chk("glitch_during", {28'h0, SYNC}, 32'h6);
    ASYNC = 4'h9; exp_q.push_back(4'h9);
    tick(8);
    chk("glitch_final", {28'h0, SYNC}, 32'h9);

    // Enable gating
    EN = 1'b0; ASYNC = 4'hA;
    tick(10);
    chk("en_hold", {28'h0, SYNC}, 32'h9);
    chk("en_hold_change", {31'h0, CHANGE}, 32'h0);
    exp_q.push_back(4'hA);
    EN = 1'b1;
    tick(1);
    chk("en_release", {28'h0, SYNC}, 32'hA);
    chk("en_release_change", {31'h0, CHANGE}, 32'h1);
    tick(3);
    chk("reaccept_no_change", {31'h0, CHANGE}, 32'h0);

    // Reset in the middle of an update
    ASYNC = 4'h3;
    tick(4);
    RST = 1'b0;
    #1;
    chk("midrst_sync", {28'h0, SYNC}, 32'h0);
    chk("midrst_valid", {31'h0, SYNC_VALID}, 32'h0);
    chk("midrst_change", {31'h0, CHANGE}, 32'h0);
    ASYNC = 4'h0;
    tick(2);
    RST = 1'b1;
    tick(2);
    chk("midrst_valid_e2", {31'h0, SYNC_VALID}, 32'h0);
    tick(1);
    chk("midrst_valid_e3", {31'h0, SYNC_VALID}, 32'h1);
    tick(4);
    chk("midrst_sync_after", {28'h0, SYNC}, 32'h0);

    // Gray counter through a full wrap
    RST_G = 1'b1;
    tick(6);
    chk("gray_start_valid", {31'h0, SYNC_VALID_G}, 32'h1);
    chk("gray_start_sync", {28'h0, SYNC_G}, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      ASYNC_G = gray_tab[k % 16];
      exp_g.push_back(4'(k % 16));
      tick(4);
    end
    tick(6);
    chk("gray_wrap_sync", {28'h0, SYNC_G}, 32'h0);
    chk("gray_no_err", {31'h0, GRAY_ERR_G}, 32'h0);

    // Two-bit jump 0000 -> 0011 decodes to 2 and sets the sticky error
    ASYNC_G = 4'b0011; exp_g.push_back(4'h2);
    tick(8);
    chk("gray_jump_sync", {28'h0, SYNC_G}, 32'h2);
    chk("gray_jump_err", {31'h0, GRAY_ERR_G}, 32'h1);
    ASYNC_G = 4'b0010; exp_g.push_back(4'h3);
    tick(8);
    chk("gray_after_sync", {28'h0, SYNC_G}, 32'h3);
    chk("gray_err_sticky", {31'h0, GRAY_ERR_G}, 32'h1);
    chk("bin_gerr_zero", {31'h0, GRAY_ERR}, 32'h0);
    RST_G = 1'b0;
    #1;
    chk("gray_err_rst", {31'h0, GRAY_ERR_G}, 32'h0);
    tick(2);

    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    chk("sb_drain_g", 32'(exp_g.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
